// File: rtl/rgb_pixel_fifo_if.sv
// Pixel stream interface for rgb_pixel_fifo: free-running input side (no ready)
// and valid/ready output side. The FIFO uses the slave view, its neighbours the master view.
interface rgb_pixel_fifo_if;
  logic       in_valid;
  logic [7:0] in_r;
  logic [7:0] in_g;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_r;
  logic [7:0] out_g;
  logic [7:0] out_b;

  modport master (
    output in_valid, in_r, in_g, in_b, out_ready,
    input  out_valid, out_r, out_g, out_b
  );

  modport slave (
    input  in_valid, in_r, in_g, in_b, out_ready,
    output out_valid, out_r, out_g, out_b
  );
endinterface

// File: rtl/rgb_pixel_fifo.sv
// RGB pixel FIFO: accepts pixels without back-pressure, drops them when full and
// flags the drop. Optional macro RGB_PIXEL_FIFO_DROP_CNT_EN adds a saturating drop counter.
module rgb_pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  rgb_pixel_fifo_if.slave          px,
  output logic [$clog2(DEPTH):0]   level,
`ifdef RGB_PIXEL_FIFO_DROP_CNT_EN
  output logic [CNT_W-1:0]         drop_count,
`endif
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [23:0]   r_mem [DEPTH];
  logic          r_overflow;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic [23:0]   w_head;

  // Full: same slot index, opposite lap (wrap bit differs).
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr == {~r_rd_ptr[AW], r_rd_ptr[AW-1:0]});
  assign w_pop   = !w_empty && px.out_ready;
  assign w_push  = px.in_valid && (!w_full || w_pop);
  assign w_drop  = px.in_valid && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // NOTE: the storage is reset on purpose so the head fields read 0 before the
  // first write; without that requirement a RAM would normally be left unreset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {px.in_r, px.in_g, px.in_b};
    end
  end

`ifdef RGB_PIXEL_FIFO_DROP_CNT_EN
  logic [CNT_W-1:0] r_drop_cnt;

  // Saturates at all-ones rather than wrapping back to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign drop_count = r_drop_cnt;
`endif

  assign w_head       = r_mem[r_rd_ptr[AW-1:0]];
  assign px.out_valid = !w_empty;
  assign px.out_r     = w_head[23:16];
  assign px.out_g     = w_head[15:8];
  assign px.out_b     = w_head[7:0];
  assign level        = r_wr_ptr - r_rd_ptr;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_rgb_pixel_fifo.sv
// Directed bench for rgb_pixel_fifo (DEPTH=4): reset state, ordering, hold,
// full/drop, push+pop when full, continuous streaming with pointer wrap, mid-run reset.
module tb_rgb_pixel_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic                   clk;
  logic                   reset;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;
`ifdef RGB_PIXEL_FIFO_DROP_CNT_EN
  logic [CNT_W-1:0]       drop_count;
`endif

  int n_cmp;
  int n_err;

  rgb_pixel_fifo_if px_if ();

  rgb_pixel_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .px         (px_if.slave),
    .level      (level),
`ifdef RGB_PIXEL_FIFO_DROP_CNT_EN
    .drop_count (drop_count),
`endif
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and samples live 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    px_if.in_valid = 1'b1;
    px_if.in_r     = r;
    px_if.in_g     = g;
    px_if.in_b     = b;
    step();
    px_if.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic fill_1_to_4();
    for (int i = 1; i <= 4; i++) push_pixel(8'(i), 8'(i + 16), 8'(i + 32));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    px_if.in_valid  = 1'b0;
    px_if.in_r      = '0;
    px_if.in_g      = '0;
    px_if.in_b      = '0;
    px_if.out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    check("rst_level",    32'(level), 0);
    check("rst_valid",    32'(px_if.out_valid), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_rgb",      32'({px_if.out_r, px_if.out_g, px_if.out_b}), 0);
`ifdef RGB_PIXEL_FIFO_DROP_CNT_EN
    check("rst_drop_cnt", 32'(drop_count), 0);
`endif

    // Single pixel, one-cycle latency, hold while not ready.
    push_pixel(8'h11, 8'h22, 8'h33);
    check("one_valid", 32'(px_if.out_valid), 1);
    check("one_level", 32'(level), 1);
    check("one_rgb",   32'({px_if.out_r, px_if.out_g, px_if.out_b}), 32'h112233);
    step();
    step();
    check("hold_valid", 32'(px_if.out_valid), 1);
    check("hold_rgb",   32'({px_if.out_r, px_if.out_g, px_if.out_b}), 32'h112233);
    px_if.out_ready = 1'b1;
    step();
    px_if.out_ready = 1'b0;
    check("one_drained", 32'(level), 0);

    // Fill to DEPTH, then drain in order.
    fill_1_to_4();
    check("fill_level", 32'(level), 4);
    px_if.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_r",     32'(px_if.out_r), 32'(i));
      check("drain_gb",    32'({px_if.out_g, px_if.out_b}), 32'({8'(i + 16), 8'(i + 32)}));
      check("drain_level", 32'(level), 32'(5 - i));
      step();
    end
    px_if.out_ready = 1'b0;
    check("drain_valid", 32'(px_if.out_valid), 0);
    check("drain_level0", 32'(level), 0);
    check("no_overflow_yet", 32'(overflow), 0);

    // Push into a full FIFO with no pop: dropped.
    fill_1_to_4();
    push_pixel(8'd5, 8'd5, 8'd5);
    check("drop_overflow", 32'(overflow), 1);
    check("drop_level",    32'(level), 4);
`ifdef RGB_PIXEL_FIFO_DROP_CNT_EN
    check("drop_cnt", 32'(drop_count), 1);
`endif
    px_if.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drop_order", 32'(px_if.out_r), 32'(i));
      step();
    end
    px_if.out_ready = 1'b0;
    check("drop_empty", 32'(px_if.out_valid), 0);

    // Full with simultaneous push and pop: push accepted.
    fill_1_to_4();
    check("pp_head", 32'(px_if.out_r), 1);
    px_if.out_ready = 1'b1;
    push_pixel(8'd6, 8'd6, 8'd6);
    px_if.out_ready = 1'b0;
    check("pp_level", 32'(level), 4);
    px_if.out_ready = 1'b1;
    check("pp_out0", 32'(px_if.out_r), 2);
    step();
    check("pp_out1", 32'(px_if.out_r), 3);
    step();
    check("pp_out2", 32'(px_if.out_r), 4);
    step();
    check("pp_last", 32'(px_if.out_r), 6);
    step();
    px_if.out_ready = 1'b0;
    check("pp_empty", 32'(px_if.out_valid), 0);
`ifdef RGB_PIXEL_FIFO_DROP_CNT_EN
    check("pp_drop_cnt", 32'(drop_count), 1);
`endif

    // Continuous streaming after reset; pointers wrap past 2*DEPTH.
    do_reset();
    px_if.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_pixel(8'(i), 8'(i), 8'(i));
      check("stream_r",     32'(px_if.out_r), 32'(i));
      check("stream_level", 32'(level), 1);
    end
    step();
    px_if.out_ready = 1'b0;
    check("stream_empty",    32'(level), 0);
    check("stream_overflow", 32'(overflow), 0);

    // Level 3 with overflow set, then reset with a push presented.
    fill_1_to_4();
    push_pixel(8'd9, 8'd9, 8'd9);
    px_if.out_ready = 1'b1;
    step();
    px_if.out_ready = 1'b0;
    check("pre_rst_level",    32'(level), 3);
    check("pre_rst_overflow", 32'(overflow), 1);
    reset = 1'b1;
    px_if.in_valid = 1'b1;
    px_if.in_r = 8'hAA;
    px_if.in_g = 8'hBB;
    px_if.in_b = 8'hCC;
    step();
    reset = 1'b0;
    px_if.in_valid = 1'b0;
    check("mid_rst_level",    32'(level), 0);
    check("mid_rst_valid",    32'(px_if.out_valid), 0);
    check("mid_rst_overflow", 32'(overflow), 0);
    check("mid_rst_rgb",      32'({px_if.out_r, px_if.out_g, px_if.out_b}), 0);
`ifdef RGB_PIXEL_FIFO_DROP_CNT_EN
    check("mid_rst_drop_cnt", 32'(drop_count), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
